// File: rtl/ysyx_25030081_ifu.sv
// Multi-cycle instruction fetch unit: owns the fetch PC, issues one read per
// instruction on an AR/R bus and hands the word to the core via valid/ready.
module ysyx_25030081_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  pc_wen,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fetch_err
);

    localparam logic [2:0] S_REQ    = 3'd0;
    localparam logic [2:0] S_WAIT_R = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_IDLE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [ADDR_WIDTH-1:0] r_inst_pc;
    logic                  r_inst_valid;
    logic                  r_arvalid;
    logic                  r_fetch_err;

    logic w_pc_aligned;
    logic w_pc_accept;

    assign w_pc_aligned = (pc_in[1:0] == 2'b00);
    // A new PC is only taken once the current instruction has been consumed
    assign w_pc_accept  = pc_wen &&
                          (((r_state == S_HOLD) && inst_ready) || (r_state == S_IDLE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_arvalid    <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else if (w_pc_accept) begin
            r_inst_valid <= 1'b0;
            if (w_pc_aligned) begin
                r_pc      <= pc_in;
                r_arvalid <= 1'b1;
                r_state   <= S_REQ;
            end else begin
                r_fetch_err <= 1'b1;
                r_state     <= S_ERR;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    // Out of reset arvalid is low; raise it on the first edge
                    if (r_arvalid && arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_WAIT_R;
                    end else begin
                        r_arvalid <= 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (rvalid) begin
                        if (rresp == 2'b00) begin
                            r_inst       <= rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end else begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_ERR;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_arvalid    <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_state      <= S_REQ;
                end
            endcase
        end
    end

    assign araddr     = r_pc;
    assign arvalid    = r_arvalid;
    assign rready     = (r_state == S_WAIT_R);
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
// Directed bench for the fetch unit: stimulus pushes expected bus requests and
// delivered instructions into queues, a monitor pops them on each handshake.
module tb_ysyx_25030081_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        pc_wen = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_ar[$];
    logic [31:0] q_inst[$];
    logic [31:0] q_inst_pc[$];

    ysyx_25030081_ifu dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_wen     (pc_wen),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs are settled by the falling edge, so what it sees here is
    // exactly what the next rising edge will accept.
    always @(negedge clk) begin
        if (rst) begin
            if (arvalid && arready) begin
                if (q_ar.size() == 0) begin
                    chk("unexpected_ar", araddr, 32'hxxxx_xxxx);
                end else begin
                    chk("ar_addr", araddr, q_ar.pop_front());
                    $display("AR   addr=%h", araddr);
                end
            end
            if (inst_valid && inst_ready) begin
                if (q_inst.size() == 0) begin
                    chk("unexpected_inst", inst, 32'hxxxx_xxxx);
                end else begin
                    chk("inst_data", inst, q_inst.pop_front());
                    chk("inst_pc", inst_pc, q_inst_pc.pop_front());
                    $display("INST pc=%h inst=%h", inst_pc, inst);
                end
            end
        end
    end

    initial begin
        // Reset state
        cyc();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_araddr", araddr, 32'h8000_0000);

        // First fetch after reset release
        rst = 1'b1;
        arready = 1'b1;
        q_ar.push_back(32'h8000_0000);
        cyc();
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_araddr", araddr, 32'h8000_0000);
        cyc();
        chk("t1_rready", 32'(rready), 32'd1);
        chk("t1_arvalid_low", 32'(arvalid), 32'd0);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0000_0413;
        rresp = 2'b00;
        cyc();
        rvalid = 1'b0;
        chk("t1_inst_valid", 32'(inst_valid), 32'd1);

        // Core stalls for 5 cycles; inst must not move
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_hold_valid", 32'(inst_valid), 32'd1);
            chk("t2_hold_inst", inst, 32'h0000_0413);
            chk("t2_hold_pc", inst_pc, 32'h8000_0000);
        end
        inst_ready = 1'b1;
        pc_wen = 1'b1;
        pc_in = 32'h8000_0004;
        q_inst.push_back(32'h0000_0413);
        q_inst_pc.push_back(32'h8000_0000);
        q_ar.push_back(32'h8000_0004);
        cyc();
        inst_ready = 1'b0;
        pc_wen = 1'b0;
        chk("t2_inst_valid_low", 32'(inst_valid), 32'd0);

        // Bus stalls the request for 4 cycles
        for (int i = 0; i < 4; i++) begin
            chk("t3_arvalid", 32'(arvalid), 32'd1);
            chk("t3_araddr", araddr, 32'h8000_0004);
            chk("t3_rready", 32'(rready), 32'd0);
            if (i < 3) cyc();
        end
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        chk("t3_wait_rready", 32'(rready), 32'd1);
        chk("t3_wait_arvalid", 32'(arvalid), 32'd0);
        rvalid = 1'b1;
        rdata = 32'h0010_0093;
        q_inst.push_back(32'h0010_0093);
        q_inst_pc.push_back(32'h8000_0004);
        cyc();
        rvalid = 1'b0;
        chk("t3_inst_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        chk("t3_idle_valid", 32'(inst_valid), 32'd0);
        // Stray response while idle must change nothing
        rvalid = 1'b1;
        rdata = 32'hdead_beef;
        cyc();
        rvalid = 1'b0;
        cyc();
        chk("t3_idle_arvalid", 32'(arvalid), 32'd0);
        chk("t3_idle_valid2", 32'(inst_valid), 32'd0);

        // Zero-latency response is ignored, then an error response arrives
        pc_wen = 1'b1;
        pc_in = 32'h8000_0008;
        arready = 1'b1;
        q_ar.push_back(32'h8000_0008);
        cyc();
        pc_wen = 1'b0;
        chk("t4_arvalid", 32'(arvalid), 32'd1);
        rvalid = 1'b1;
        rdata = 32'h1234_5678;
        rresp = 2'b00;
        cyc();
        arready = 1'b0;
        chk("t4_zero_lat_ignored", 32'(inst_valid), 32'd0);
        chk("t4_wait_rready", 32'(rready), 32'd1);
        rresp = 2'b10;
        cyc();
        rvalid = 1'b0;
        rresp = 2'b00;
        chk("t4_fetch_err", 32'(fetch_err), 32'd1);
        chk("t4_no_inst", 32'(inst_valid), 32'd0);
        pc_wen = 1'b1;
        pc_in = 32'h8000_000c;
        inst_ready = 1'b1;
        arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_err_arvalid", 32'(arvalid), 32'd0);
            chk("t4_err_rready", 32'(rready), 32'd0);
            chk("t4_err_sticky", 32'(fetch_err), 32'd1);
        end
        pc_wen = 1'b0;
        inst_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("t4_rst_err_clear", 32'(fetch_err), 32'd0);
        chk("t4_rst_araddr", araddr, 32'h8000_0000);
        cyc();
        rst = 1'b1;
        q_ar.push_back(32'h8000_0000);
        cyc();
        chk("t4_restart_arvalid", 32'(arvalid), 32'd1);
        chk("t4_restart_araddr", araddr, 32'h8000_0000);
        cyc();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0020_0113;
        q_inst.push_back(32'h0020_0113);
        q_inst_pc.push_back(32'h8000_0000);
        cyc();
        rvalid = 1'b0;
        chk("t4_restart_inst_valid", 32'(inst_valid), 32'd1);

        // Misaligned next PC
        inst_ready = 1'b1;
        pc_wen = 1'b1;
        pc_in = 32'h8000_0006;
        cyc();
        inst_ready = 1'b0;
        pc_wen = 1'b0;
        arready = 1'b1;
        chk("t5_fetch_err", 32'(fetch_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_arvalid", 32'(arvalid), 32'd0);
            cyc();
        end
        arready = 1'b0;

        // Reset during WAIT_R with responses around the reset
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        arready = 1'b1;
        q_ar.push_back(32'h8000_0000);
        cyc();
        cyc();
        arready = 1'b0;
        chk("t6_in_wait", 32'(rready), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_rready", 32'(rready), 32'd0);
        chk("t6_rst_arvalid", 32'(arvalid), 32'd0);
        rvalid = 1'b1;
        rdata = 32'hdead_dead;
        cyc();
        rst = 1'b1;
        cyc();
        rvalid = 1'b0;
        chk("t6_no_inst", 32'(inst_valid), 32'd0);
        chk("t6_arvalid", 32'(arvalid), 32'd1);
        chk("t6_araddr", araddr, 32'h8000_0000);
        q_ar.push_back(32'h8000_0000);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0030_0193;
        q_inst.push_back(32'h0030_0193);
        q_inst_pc.push_back(32'h8000_0000);
        cyc();
        rvalid = 1'b0;
        chk("t6_inst_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        cyc();

        chk("end_ar_queue", 32'(q_ar.size()), 32'd0);
        chk("end_inst_queue", 32'(q_inst.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25030081_ifu.md
Name: ysyx_25030081_ifu

Overview:
Multi-cycle instruction fetch unit that sits directly upstream of the CPU core's decode/execute datapath, which consumes `inst` and supplies the next PC.
- Holds the architectural fetch PC and issues one read per instruction on a valid/ready SRAM-style bus (AR and R channels).
- Presents the returned word to the core through a valid/ready handshake.
- Replaces the combinational `inst` feed, so the core can advance only when a fetched instruction is valid.

Parameters:
- ADDR_WIDTH, 32, width of PC and bus address.
- DATA_WIDTH, 32, width of instruction and bus read data.
- RESET_PC, 32'h8000_0000, fetch address loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  in  ADDR_WIDTH  next PC from core (branch/jump/pc+4 result).
- pc_wen  in  1  core commits pc_in as next fetch address.
- araddr  out  ADDR_WIDTH  bus read address.
- arvalid  out  1  read request valid.
- arready  in  1  bus accepts request.
- rdata  in  DATA_WIDTH  bus read data.
- rresp  in  2  read response; 2'b00 = OKAY, anything else = error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst  out  DATA_WIDTH  fetched instruction to core.
- inst_pc  out  ADDR_WIDTH  address of `inst`.
- inst_valid  out  1  `inst` and `inst_pc` are valid.
- inst_ready  in  1  core consumes `inst` this cycle.
- fetch_err  out  1  sticky fault flag.

Behaviour:
Reset (rst=0, takes effect immediately, asynchronous to clk):
- State=REQ, pc_q=RESET_PC, inst=0, inst_pc=0.
- inst_valid=0, arvalid=0, rready=0, fetch_err=0.
- arvalid is a registered output, so the first request appears on the first clk edge after rst deasserts.

FSM states: REQ, WAIT_R, HOLD, IDLE, ERR.
- REQ: arvalid=1, araddr=pc_q. araddr and arvalid stay stable until arready. On arvalid&&arready -> WAIT_R.
- WAIT_R: rready=1, arvalid=0. On rvalid:
  - rresp==0: inst<=rdata, inst_pc<=pc_q, inst_valid<=1, -> HOLD.
  - rresp!=0: fetch_err<=1, -> ERR.
- HOLD: inst_valid=1. inst and inst_pc stay stable until inst_ready.
  - inst_ready && pc_wen (same cycle): pc_q<=pc_in, inst_valid<=0, -> REQ.
  - inst_ready only: inst_valid<=0, -> IDLE.
- IDLE: wait for pc_wen, then pc_q<=pc_in, -> REQ.
- ERR: terminal until reset. All handshake outputs are 0; fetch_err=1.

PC alignment:
- If pc_in[1:0]!=2'b00 when accepted: fetch_err<=1, -> ERR, no bus request is issued.
- RESET_PC must be word-aligned.

Unexpected pc_wen:
- pc_wen in REQ or WAIT_R, or in HOLD without inst_ready, is ignored. pc_q is unchanged; the core must not do this.

Bus rules:
- At most one outstanding read.
- rvalid outside WAIT_R is ignored and does not alter state.
- An rvalid arriving in the same cycle as arready (zero-latency bus) is not accepted; the response is taken in WAIT_R on a later cycle.

Latency (arready and rvalid asserted as early as allowed):
- pc_wen accepted at edge N -> arvalid high in cycle N+1 -> WAIT_R from N+2 -> rvalid sampled at edge N+2 -> inst_valid high in cycle N+3.
- Steady-state throughput: 1 instruction per 3 cycles.

Reset mid-operation:
- Any state returns to REQ at RESET_PC.
- An in-flight bus response is discarded, because rready=0 until WAIT_R is re-entered.

Test Plan:
- Reset release, arready=1, 1-cycle rvalid, rdata=32'h00000413 -> araddr=32'h80000000 on the first cycle after reset; inst_valid=1 with inst=32'h00000413 and inst_pc=32'h80000000 two cycles later.
- Hold inst_ready=0 for 5 cycles, then pulse inst_ready+pc_wen with pc_in=32'h80000004 -> inst and inst_pc stable for all 5 cycles; the next cycle has arvalid=1 with araddr=32'h80000004.
- arready held 0 for 4 cycles in REQ -> araddr and arvalid stable throughout; transition to WAIT_R only on the arready edge.
- rvalid with rresp=2'b10 -> fetch_err=1 and inst_valid stays 0; further pc_wen is ignored until rst pulses low, after which fetch restarts at 32'h80000000.
- pc_wen with pc_in=32'h80000006 -> fetch_err=1 and arvalid is never asserted.
- Assert rst low while in WAIT_R, deliver rvalid during reset and then 1 cycle after release -> both responses are ignored; a fresh arvalid is issued at 32'h80000000.
